// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor table.
package bp_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  localparam int unsigned MISS_W = 16;
  localparam logic [MISS_W-1:0] MISS_MAX = '1;

endpackage

// File: rtl/sat_counter_next.sv
// Next value of a CTR_W-bit saturating up/down counter; never wraps.
module sat_counter_next #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             inc,
  output logic [CTR_W-1:0] ctr_next
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != CTR_MAX) ctr_next = ctr + CTR_W'(1);
    end else begin
      if (ctr != '0) ctr_next = ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_table.sv
// Bimodal branch predictor table with power-up init sweep and miss counter.
// Define GSHARE_EN to hash the request index with a global history register.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned HIST_W   = 4,
  parameter int unsigned INIT_CTR = (2 ** CTR_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [IDX_W-1:0]  req_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [CTR_W-1:0]  pred_ctr,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_pred,
  output logic              ready,
  output logic [MISS_W-1:0] miss_cnt
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  // Elaboration-time parameter legality
  if (CTR_W < 1 || CTR_W > 4) begin : g_bad_ctr_w
    $error("CTR_W must be in 1..4");
  end
  if (HIST_W < 1 || HIST_W > IDX_W) begin : g_bad_hist_w
    $error("HIST_W must be in 1..IDX_W");
  end

  bp_state_e         state_q, state_d;
  logic [IDX_W-1:0]  sweep_q, sweep_d;
  logic              ready_q, ready_d;
  logic              pred_valid_q, pred_valid_d;
  logic              pred_taken_q, pred_taken_d;
  logic [CTR_W-1:0]  pred_ctr_q, pred_ctr_d;
  logic [IDX_W-1:0]  pred_idx_q, pred_idx_d;
  logic [MISS_W-1:0] miss_q, miss_d;

  logic [CTR_W-1:0]  table_q [DEPTH];

  logic              init_we_c;
  logic              run_c;
  logic              req_acc_c;
  logic              upd_acc_c;
  logic [IDX_W-1:0]  req_idx_c;
  logic [CTR_W-1:0]  upd_old_c;
  logic [CTR_W-1:0]  upd_new_c;
  logic [CTR_W-1:0]  req_ctr_c;

  // Init sweep / run state machine
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    init_we_c = 1'b0;
    run_c     = 1'b0;
    case (state_q)
      INIT: begin
        init_we_c = 1'b1;
        sweep_d   = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN:     run_c   = 1'b1;
      default: state_d = INIT;
    endcase
    ready_d = (state_d == RUN);
  end

`ifdef GSHARE_EN
  logic [HIST_W-1:0] ghr_q, ghr_d;

  // Truncating cast keeps the newest HIST_W outcomes, also for HIST_W = 1
  always_comb begin
    ghr_d = ghr_q;
    if (upd_acc_c) ghr_d = HIST_W'({ghr_q, upd_taken});
  end

  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

  assign req_idx_c = req_pc ^ IDX_W'(ghr_q);
`else
  assign req_idx_c = req_pc;
`endif

  assign req_acc_c = run_c & req_valid;
  assign upd_acc_c = run_c & upd_valid;
  assign upd_old_c = table_q[upd_idx];

  sat_counter_next #(
    .CTR_W (CTR_W)
  ) u_sat (
    .ctr      (upd_old_c),
    .inc      (upd_taken),
    .ctr_next (upd_new_c)
  );

  // Same-index update forwards its new value into the prediction
  always_comb begin
    req_ctr_c = table_q[req_idx_c];
    if (upd_acc_c && (upd_idx == req_idx_c)) req_ctr_c = upd_new_c;

    pred_valid_d = req_acc_c;
    pred_taken_d = pred_taken_q;
    pred_ctr_d   = pred_ctr_q;
    pred_idx_d   = pred_idx_q;
    if (req_acc_c) begin
      pred_taken_d = req_ctr_c[CTR_W-1];
      pred_ctr_d   = req_ctr_c;
      pred_idx_d   = req_idx_c;
    end

    miss_d = miss_q;
    if (upd_acc_c && (upd_taken != upd_pred) && (miss_q != MISS_MAX)) begin
      miss_d = miss_q + MISS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      ready_q      <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ctr_q   <= '0;
      pred_idx_q   <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      ready_q      <= ready_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_ctr_q   <= pred_ctr_d;
      pred_idx_q   <= pred_idx_d;
      miss_q       <= miss_d;
    end
  end

  // Counter storage is not reset; the sweep defines every entry before use
  always_ff @(posedge clk) begin
    if (init_we_c)      table_q[sweep_q] <= CTR_W'(INIT_CTR);
    else if (upd_acc_c) table_q[upd_idx] <= upd_new_c;
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_ctr   = pred_ctr_q;
  assign pred_idx   = pred_idx_q;
  assign ready      = ready_q;
  assign miss_cnt   = miss_q;

endmodule

// File: doc/branch_predictor_table.md
BRANCH_PREDICTOR_TABLE -- requirements
Module: branch_predictor_table

Interface
REQ-001 SHALL have parameter IDX_W, default 4, index width; table depth DEPTH = 2**IDX_W.
REQ-002 SHALL have parameter CTR_W, default 2, saturating counter width, legal range 1..4.
REQ-003 SHALL have parameter HIST_W, default 4, global history width, legal range 1..IDX_W.
REQ-004 SHALL have parameter INIT_CTR, default 2**CTR_W-1 (strongly taken), counter reset value.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 Port list:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  prediction request.
- req_pc  in  IDX_W  branch PC index bits.
- pred_valid  out  1  prediction present, one cycle after accepted request.
- pred_taken  out  1  predicted direction, counter MSB.
- pred_ctr  out  CTR_W  counter value used for the prediction.
- pred_idx  out  IDX_W  table index used; the caller echoes it on update.
- upd_valid  in  1  resolved-branch update.
- upd_idx  in  IDX_W  entry to train.
- upd_taken  in  1  actual outcome.
- upd_pred  in  1  direction originally predicted, used for miss counting.
- ready  out  1  table initialised, accepting traffic.
- miss_cnt  out  16  saturating misprediction count.

Function
REQ-007 SHALL implement FSM states INIT and RUN; rst forces INIT.
REQ-008 INIT SHALL write INIT_CTR to one entry per cycle, index 0..DEPTH-1, then enter RUN on the cycle after index DEPTH-1 is written.
REQ-009 In INIT: ready=0, req_valid and upd_valid ignored, pred_valid=0.
REQ-010 In RUN: ready=1.
REQ-011 A request accepted in cycle N SHALL produce pred_valid=1 in cycle N+1 with registered pred_taken, pred_ctr and pred_idx; pred_valid SHALL be 0 otherwise.
REQ-012 Counter update on upd_valid in RUN: upd_taken=1 increments, saturating at 2**CTR_W-1; upd_taken=0 decrements, saturating at 0; no wrap-around.
REQ-013 Update written at the clock edge; only the entry at upd_idx is modified.
REQ-014 Request and update to the same index in the same cycle SHALL forward: the prediction reflects the post-update counter.
REQ-015 Request and update to different indices in the same cycle SHALL proceed independently.
REQ-016 Without GSHARE_EN, request index = req_pc.
REQ-017 miss_cnt SHALL increment when upd_valid and upd_taken != upd_pred in RUN, and saturate at 16'hFFFF.
REQ-018 Outputs SHALL hold their value when no event occurs, except pred_valid, which is a one-cycle pulse.

Reset
REQ-019 Reset values: pred_valid=0, pred_taken=0, pred_ctr=0, pred_idx=0, ready=0, miss_cnt=0, GHR=0, sweep index=0, state=INIT.
REQ-020 rst asserted mid-INIT or mid-RUN SHALL abort any pending prediction and restart the sweep from index 0.
REQ-021 Table contents are undefined until the sweep completes and are never observable before ready=1.

Configuration
REQ-022 Macro GSHARE_EN: when defined, a HIST_W global history register (GHR) is compiled in.
REQ-023 With GSHARE_EN, request index = req_pc XOR zero-extended GHR.
REQ-024 With GSHARE_EN, on each RUN upd_valid, GHR <= {GHR[HIST_W-2:0], upd_taken}; for HIST_W=1, GHR <= upd_taken.
REQ-025 With GSHARE_EN, a request in the same cycle as a GHR shift hashes with the pre-shift GHR.
REQ-026 Without GSHARE_EN: no GHR storage; behaviour is pure bimodal.

Structure
REQ-027 Shared package bp_pkg SHALL hold the FSM state typedef (INIT, RUN) and the miss-counter width constant (16).
REQ-028 Per-entry saturating logic SHALL live in sub-module sat_counter_next, combinational, parameter CTR_W: inputs ctr, inc; output next value.
REQ-029 The table is a register array; no RAM macro.

Verification
REQ-030 Default parameters; rst for 1 cycle, then idle -> ready=0 for exactly 16 cycles, then ready=1; first request on any pc -> pred_taken=1, pred_ctr=3.
REQ-031 After init, three upd_valid on idx 5 with taken=0 -> request pc 5 gives pred_ctr=0, pred_taken=0; a fourth taken=0 update leaves pred_ctr=0.
REQ-032 Same-cycle update idx 2 taken=0 (ctr 3) and request pc 2 -> next cycle pred_ctr=2, pred_taken=1.
REQ-033 Updates with upd_pred != upd_taken for 70000 updates -> miss_cnt=16'hFFFF and holds; rst -> miss_cnt=0, ready=0.
REQ-034 GSHARE_EN: updates taken=1,0,1,1 -> GHR=4'b1011; request pc 4'b0001 -> pred_idx=4'b1010.
REQ-035 Assert rst at sweep index 7 -> sweep restarts; ready rises 16 cycles after rst deasserts; requests during INIT give pred_valid=0.
